// File: rtl/cpu_pkg.sv
// cpu_pkg: shared memory-access FSM states, bus width defaults and SRAM control idle value
package cpu_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, HOLD} mau_state_t;
  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 16;
  localparam logic [2:0] SRAM_CTRL_IDLE = 3'b111;
endpackage

// File: rtl/mem_access_unit.sv
// mem_access_unit: strobe-driven async SRAM cycle sequencer with registered pins and wait states
module mem_access_unit
  import cpu_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int WAIT_STATES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_valid,
  output logic              busy,
  output logic              err,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_dq_o,
  input  logic [DATA_W-1:0] sram_dq_i,
  output logic              sram_dq_oe,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n
);
  mau_state_t state, state_d;
  logic [3:0] cnt, cnt_d;
  logic wr, wr_d, strobe, accept, last;
  always_comb begin
    strobe  = mem_read | mem_write;
    accept  = strobe && state == IDLE;
    last    = state == ACCESS && cnt == 4'd0;
    wr_d    = accept ? mem_write : wr;
    cnt_d   = state == SETUP ? 4'(WAIT_STATES - 1) : state == ACCESS ? cnt - 4'd1 : cnt;
    state_d = accept ? SETUP : state == SETUP ? ACCESS : last ? HOLD : state == HOLD ? IDLE : state;
  end
  assign busy = state != IDLE;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      wr          <= 1'b0;
      rdata       <= '0;
      rdata_valid <= 1'b0;
      err         <= 1'b0;
      sram_addr   <= '0;
      sram_dq_o   <= '0;
      sram_dq_oe  <= 1'b0;
      {sram_ce_n, sram_oe_n, sram_we_n} <= SRAM_CTRL_IDLE;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      wr    <= wr_d;
      if (accept) begin
        sram_addr <= addr;
        sram_dq_o <= wdata;
      end
      if ((mem_read && mem_write) || (strobe && !accept)) err <= 1'b1;
      // pins are registered from the next state so they change with the state itself
      sram_ce_n   <= state_d == IDLE;
      sram_oe_n   <= !(!wr_d && (state_d == SETUP || state_d == ACCESS));
      sram_we_n   <= !(wr_d && state_d == ACCESS);
      sram_dq_oe  <= wr_d && state_d != IDLE;
      rdata_valid <= last && !wr;
      if (last && !wr) rdata <= sram_dq_i;
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed checks of read/write timing, protocol errors, reset abort and wait states
module tb_mem_access_unit;
  logic clk = 1'b0, rst_n = 1'b0, preload = 1'b1;
  logic mem_read = 1'b0, mem_write = 1'b0, rd1 = 1'b0, rd15 = 1'b0;
  logic [15:0] addr = '0, wdata = '0;
  logic [15:0] rdata, sram_addr, sram_dq_o, sram_dq_i;
  logic rdata_valid, busy, err, sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n;
  logic [15:0] rdata1, sram_addr1, sram_dq_o1, rdata15, sram_addr15, sram_dq_o15;
  logic v1, b1, e1, oe1, ce1, oen1, we1, v15, b15, e15, oe15, ce15, oen15, we15;
  logic [15:0] mem [0:255];
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  assign sram_dq_i = mem[sram_addr[7:0]];
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
      mem[8'h10] <= 16'hBEEF;
    end else if (!sram_we_n && !sram_ce_n && sram_dq_oe) mem[sram_addr[7:0]] <= sram_dq_o;
  end
  mem_access_unit #(.ADDR_W(16), .DATA_W(16), .WAIT_STATES(2)) dut (
    .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write), .addr(addr), .wdata(wdata),
    .rdata(rdata), .rdata_valid(rdata_valid), .busy(busy), .err(err), .sram_addr(sram_addr),
    .sram_dq_o(sram_dq_o), .sram_dq_i(sram_dq_i), .sram_dq_oe(sram_dq_oe), .sram_ce_n(sram_ce_n),
    .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n));
  mem_access_unit #(.ADDR_W(16), .DATA_W(16), .WAIT_STATES(1)) u1 (
    .clk(clk), .rst_n(rst_n), .mem_read(rd1), .mem_write(1'b0), .addr(addr), .wdata(wdata),
    .rdata(rdata1), .rdata_valid(v1), .busy(b1), .err(e1), .sram_addr(sram_addr1),
    .sram_dq_o(sram_dq_o1), .sram_dq_i(16'hC001), .sram_dq_oe(oe1), .sram_ce_n(ce1),
    .sram_oe_n(oen1), .sram_we_n(we1));
  mem_access_unit #(.ADDR_W(16), .DATA_W(16), .WAIT_STATES(15)) u15 (
    .clk(clk), .rst_n(rst_n), .mem_read(rd15), .mem_write(1'b0), .addr(addr), .wdata(wdata),
    .rdata(rdata15), .rdata_valid(v15), .busy(b15), .err(e15), .sram_addr(sram_addr15),
    .sram_dq_o(sram_dq_o15), .sram_dq_i(16'hF15F), .sram_dq_oe(oe15), .sram_ce_n(ce15),
    .sram_oe_n(oen15), .sram_we_n(we15));

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_strobe(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d);
    mem_read = r;
    mem_write = w;
    addr = a;
    wdata = d;
    step();
    mem_read = 1'b0;
    mem_write = 1'b0;
  endtask

  task automatic test_reset;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if ({rdata, rdata_valid, busy, err, sram_addr, sram_dq_o, sram_dq_oe} !== 52'd0)
        begin failures++; $display("FAIL reset_zero c=%0d got rdata=%h v=%b busy=%b err=%b addr=%h dq=%h oe=%b exp all 0", c, rdata, rdata_valid, busy, err, sram_addr, sram_dq_o, sram_dq_oe); end
      checks++;
      if ({sram_ce_n, sram_oe_n, sram_we_n} !== 3'b111)
        begin failures++; $display("FAIL reset_ctrl c=%0d got %b exp 111", c, {sram_ce_n, sram_oe_n, sram_we_n}); end
      checks++;
      if ({b1, v1, b15, v15} !== 4'b0)
        begin failures++; $display("FAIL reset_wvar c=%0d got %b exp 0000", c, {b1, v1, b15, v15}); end
      @(posedge clk);
    end
    #1;
    rst_n = 1'b1;
    preload = 1'b0;
    step();
  endtask

  task automatic test_read;
    do_strobe(1'b1, 1'b0, 16'h0010, 16'h0);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      checks++;
      if (sram_oe_n !== !(c <= 3)) begin failures++; $display("FAIL read_oe_n c=%0d got %b exp %b", c, sram_oe_n, !(c <= 3)); end
      checks++;
      if (busy !== (c <= 4)) begin failures++; $display("FAIL read_busy c=%0d got %b exp %b", c, busy, c <= 4); end
      checks++;
      if (sram_ce_n !== !(c <= 4)) begin failures++; $display("FAIL read_ce_n c=%0d got %b exp %b", c, sram_ce_n, !(c <= 4)); end
      checks++;
      if (rdata_valid !== (c == 4)) begin failures++; $display("FAIL read_valid c=%0d got %b exp %b", c, rdata_valid, c == 4); end
      checks++;
      if ({sram_we_n, sram_dq_oe} !== 2'b10) begin failures++; $display("FAIL read_we_oe c=%0d got %b exp 10", c, {sram_we_n, sram_dq_oe}); end
      if (c == 1) begin
        checks++;
        if (sram_addr !== 16'h0010) begin failures++; $display("FAIL read_addr got %h exp 0010", sram_addr); end
      end
      if (c >= 4) begin
        checks++;
        if (rdata !== 16'hBEEF) begin failures++; $display("FAIL read_data c=%0d got %h exp beef", c, rdata); end
      end
      step();
    end
  endtask

  task automatic test_write;
    do_strobe(1'b0, 1'b1, 16'h0020, 16'h1234);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      checks++;
      if (sram_we_n !== !(c >= 2 && c <= 3)) begin failures++; $display("FAIL write_we_n c=%0d got %b exp %b", c, sram_we_n, !(c >= 2 && c <= 3)); end
      checks++;
      if (sram_dq_oe !== (c <= 4)) begin failures++; $display("FAIL write_dq_oe c=%0d got %b exp %b", c, sram_dq_oe, c <= 4); end
      checks++;
      if (sram_oe_n !== 1'b1 || rdata_valid !== 1'b0) begin failures++; $display("FAIL write_oe_valid c=%0d got oe_n=%b v=%b exp 1 0", c, sram_oe_n, rdata_valid); end
      if (c <= 4) begin
        checks++;
        if (sram_dq_o !== 16'h1234 || sram_addr !== 16'h0020) begin failures++; $display("FAIL write_bus c=%0d got dq=%h addr=%h exp 1234 0020", c, sram_dq_o, sram_addr); end
      end
      step();
    end
    checks++;
    if (mem[8'h20] !== 16'h1234) begin failures++; $display("FAIL write_mem got %h exp 1234", mem[8'h20]); end
    checks++;
    if (err !== 1'b0 || rdata !== 16'hBEEF) begin failures++; $display("FAIL write_err_rdata got err=%b rdata=%h exp 0 beef", err, rdata); end
    do_strobe(1'b1, 1'b0, 16'h0020, 16'h0);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      checks++;
      if (rdata_valid !== (c == 4)) begin failures++; $display("FAIL wr_readback_valid c=%0d got %b exp %b", c, rdata_valid, c == 4); end
      if (c == 4) begin
        checks++;
        if (rdata !== 16'h1234) begin failures++; $display("FAIL wr_readback_data got %h exp 1234", rdata); end
      end
      step();
    end
    step();
  endtask

  task automatic test_overlap;
    do_strobe(1'b1, 1'b0, 16'h0010, 16'h0);
    step();
    do_strobe(1'b0, 1'b1, 16'h0040, 16'h9999);
    @(negedge clk);
    checks++;
    if (err !== 1'b1) begin failures++; $display("FAIL overlap_err got %b exp 1", err); end
    checks++;
    if (sram_addr !== 16'h0010 || sram_we_n !== 1'b1 || sram_oe_n !== 1'b0) begin failures++; $display("FAIL overlap_inflight got addr=%h we_n=%b oe_n=%b exp 0010 1 0", sram_addr, sram_we_n, sram_oe_n); end
    step();
    @(negedge clk);
    checks++;
    if (rdata_valid !== 1'b1 || rdata !== 16'hBEEF) begin failures++; $display("FAIL overlap_first got v=%b rdata=%h exp 1 beef", rdata_valid, rdata); end
    step();
    do_strobe(1'b1, 1'b0, 16'h0020, 16'h0);
    for (int c = 6; c <= 10; c++) begin
      @(negedge clk);
      checks++;
      if (busy !== (c <= 9)) begin failures++; $display("FAIL overlap_second_busy c=%0d got %b exp %b", c, busy, c <= 9); end
      checks++;
      if (rdata_valid !== (c == 9)) begin failures++; $display("FAIL overlap_second_valid c=%0d got %b exp %b", c, rdata_valid, c == 9); end
      if (c == 9) begin
        checks++;
        if (rdata !== 16'h1234 || sram_addr !== 16'h0020) begin failures++; $display("FAIL overlap_second_data got rdata=%h addr=%h exp 1234 0020", rdata, sram_addr); end
      end
      step();
    end
    checks++;
    if (mem[8'h40] !== 16'h0000 || err !== 1'b1) begin failures++; $display("FAIL overlap_dropped got mem40=%h err=%b exp 0000 1", mem[8'h40], err); end
  endtask

  task automatic test_reset_mid;
    do_strobe(1'b0, 1'b1, 16'h0050, 16'h7777);
    step();
    rst_n = 1'b0;
    step();
    @(negedge clk);
    checks++;
    if ({sram_ce_n, sram_oe_n, sram_we_n} !== 3'b111) begin failures++; $display("FAIL rstmid_ctrl got %b exp 111", {sram_ce_n, sram_oe_n, sram_we_n}); end
    checks++;
    if ({sram_dq_oe, busy, err, rdata_valid} !== 4'b0) begin failures++; $display("FAIL rstmid_flags got %b exp 0000", {sram_dq_oe, busy, err, rdata_valid}); end
    checks++;
    if (sram_addr !== 16'h0 || sram_dq_o !== 16'h0 || rdata !== 16'h0) begin failures++; $display("FAIL rstmid_regs got addr=%h dq=%h rdata=%h exp 0", sram_addr, sram_dq_o, rdata); end
    rst_n = 1'b1;
    step();
    do_strobe(1'b1, 1'b0, 16'h0010, 16'h0);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      checks++;
      if (rdata_valid !== (c == 4)) begin failures++; $display("FAIL rstmid_read_valid c=%0d got %b exp %b", c, rdata_valid, c == 4); end
      if (c == 4) begin
        checks++;
        if (rdata !== 16'hBEEF) begin failures++; $display("FAIL rstmid_read_data got %h exp beef", rdata); end
      end
      step();
    end
    step();
  endtask

  task automatic test_both;
    do_strobe(1'b1, 1'b1, 16'h0030, 16'h00FF);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      checks++;
      if (err !== 1'b1 || rdata_valid !== 1'b0) begin failures++; $display("FAIL both_err_valid c=%0d got err=%b v=%b exp 1 0", c, err, rdata_valid); end
      checks++;
      if (sram_we_n !== !(c >= 2 && c <= 3) || sram_oe_n !== 1'b1) begin failures++; $display("FAIL both_ctrl c=%0d got we_n=%b oe_n=%b exp %b 1", c, sram_we_n, sram_oe_n, !(c >= 2 && c <= 3)); end
      step();
    end
    checks++;
    if (mem[8'h30] !== 16'h00FF || rdata !== 16'hBEEF) begin failures++; $display("FAIL both_result got mem30=%h rdata=%h exp 00ff beef", mem[8'h30], rdata); end
  endtask

  task automatic test_wait_states;
    rd1 = 1'b1;
    rd15 = 1'b1;
    addr = 16'h0007;
    step();
    rd1 = 1'b0;
    rd15 = 1'b0;
    for (int c = 1; c <= 19; c++) begin
      @(negedge clk);
      checks++;
      if (v1 !== (c == 3)) begin failures++; $display("FAIL w1_valid c=%0d got %b exp %b", c, v1, c == 3); end
      checks++;
      if (v15 !== (c == 17)) begin failures++; $display("FAIL w15_valid c=%0d got %b exp %b", c, v15, c == 17); end
      checks++;
      if (b15 !== (c <= 17) || b1 !== (c <= 3)) begin failures++; $display("FAIL wvar_busy c=%0d got b1=%b b15=%b exp %b %b", c, b1, b15, c <= 3, c <= 17); end
      checks++;
      if (oen15 !== !(c <= 16)) begin failures++; $display("FAIL w15_oe_n c=%0d got %b exp %b", c, oen15, !(c <= 16)); end
      if (c == 3) begin
        checks++;
        if (rdata1 !== 16'hC001) begin failures++; $display("FAIL w1_data got %h exp c001", rdata1); end
      end
      if (c == 17) begin
        checks++;
        if (rdata15 !== 16'hF15F) begin failures++; $display("FAIL w15_data got %h exp f15f", rdata15); end
      end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_overlap();
    test_reset_mid();
    test_both();
    test_wait_states();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
